mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_pkg.sv | 14 +
 rtl/wr_fifo_cam.sv | 83 ++++++++
 rtl/mem_req_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_req_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory request controller: default widths,
// RAM read truncation width and the controller FSM state encoding.
package mem_pkg;

  localparam int AW_DEFAULT  = 7;
  localparam int DW_DEFAULT  = 16;

  // The RAM only returns the low 7 bits of a word on a read.
  localparam int RAM_RD_BITS = 7;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RD_WAIT = 1'b1;

endpackage

// File: rtl/wr_fifo_cam.sv
// Posted-write buffer: a FIFO of {addr, data} entries that drains its head
// every cycle it is non-empty, plus an address search across all valid
// entries that returns the data of the newest match.
module wr_fifo_cam import mem_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  output logic          head_valid,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty,
  input  logic [AW-1:0] search_addr,
  output logic          hit,
  output logic [DW-1:0] hit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;
  logic [PW-1:0] idx;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign do_push    = push && !full;
  assign do_pop     = !empty;
  assign head_valid = !empty;
  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a push and pop together leave count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: only entries below count are ever looked at.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Scan oldest to newest so a later match overrides an earlier one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (addr_mem[idx] == search_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory request controller: writes are posted into a buffer that drains to
// RAM port 0; reads either forward from the buffer or go to RAM port 1, and
// return a response one cycle after acceptance.
module mem_req_ctrl import mem_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          wb_empty,
  output logic          ram_read_en0,
  output logic          ram_write_en0,
  output logic [AW-1:0] ram_addr0,
  output logic [DW-1:0] ram_din0,
  output logic          ram_read_en1,
  output logic          ram_write_en1,
  output logic [AW-1:0] ram_addr1,
  output logic [DW-1:0] ram_din1,
  input  logic [DW-1:0] ram_dout1
);

  logic [0:0]    state;
  logic          wb_full;
  logic          head_valid;
  logic          accept;
  logic          wr_push;
  logic          rd_accept;
  logic          cam_hit;
  logic [DW-1:0] cam_data;
  logic [DW-1:0] fwd_trunc;
  logic          fwd_hit_q;
  logic [DW-1:0] fwd_data_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rsp_live;

  // Requests are refused while a read is outstanding, the buffer is full,
  // or reset is held, so nothing reaches the RAM during reset.
  assign req_ready = rst_n && (state == ST_IDLE) && !wb_full;
  assign accept    = req_valid && req_ready;
  assign wr_push   = accept && req_we;
  assign rd_accept = accept && !req_we;

  wr_fifo_cam #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_wr_fifo_cam (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (wr_push),
    .push_addr  (req_addr),
    .push_data  (req_wdata),
    .head_valid (head_valid),
    .head_addr  (ram_addr0),
    .head_data  (ram_din0),
    .full       (wb_full),
    .empty      (wb_empty),
    .search_addr(req_addr),
    .hit        (cam_hit),
    .hit_data   (cam_data)
  );

  assign ram_read_en0  = 1'b0;
  assign ram_write_en0 = head_valid;
  assign ram_write_en1 = 1'b0;
  assign ram_din1      = '0;
  assign ram_read_en1  = rd_accept && !cam_hit;
  assign ram_addr1     = req_addr;

  // Forwarded data is cut to the bits a RAM read would have returned.
  always_comb begin
    fwd_trunc = '0;
    fwd_trunc[RAM_RD_BITS-1:0] = cam_data[RAM_RD_BITS-1:0];
  end

  // Two-state FSM: an accepted read waits exactly one cycle for its response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (rd_accept) state <= ST_RD_WAIT;
        ST_RD_WAIT: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Capture the forwarding decision and data when the read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else if (rd_accept) begin
      fwd_hit_q  <= cam_hit;
      fwd_data_q <= fwd_trunc;
    end
  end

  assign rsp_valid = (state == ST_RD_WAIT);
  assign rsp_live  = fwd_hit_q ? fwd_data_q : ram_dout1;
  assign rsp_rdata = rsp_valid ? rsp_live : rdata_q;

  // Remember the last response so rsp_rdata holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rsp_valid) begin
      rdata_q <= rsp_live;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl with hand-computed expectations.
module tb_mem_req_ctrl;

  localparam int AW = 7;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          wb_empty;
  logic          ram_read_en0;
  logic          ram_write_en0;
  logic [AW-1:0] ram_addr0;
  logic [DW-1:0] ram_din0;
  logic          ram_read_en1;
  logic          ram_write_en1;
  logic [AW-1:0] ram_addr1;
  logic [DW-1:0] ram_din1;
  logic [DW-1:0] ram_dout1;

  int checks   = 0;
  int failures = 0;

  mem_req_ctrl #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .wb_empty     (wb_empty),
    .ram_read_en0 (ram_read_en0),
    .ram_write_en0(ram_write_en0),
    .ram_addr0    (ram_addr0),
    .ram_din0     (ram_din0),
    .ram_read_en1 (ram_read_en1),
    .ram_write_en1(ram_write_en1),
    .ram_addr1    (ram_addr1),
    .ram_din1     (ram_din1),
    .ram_dout1    (ram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic we,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    ram_dout1 = '0;
    #3;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    checkOutput("rst_wb_empty", 32'(wb_empty), 32'h1);
    checkOutput("rst_wen0", 32'(ram_write_en0), 32'h0);
    checkOutput("rst_ren1", 32'(ram_read_en1), 32'h0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    $display("[TB] single write");
    applyStimulus(1'b1, 1'b1, 7'd5, 16'h1234);
    checkOutput("w1_ready", 32'(req_ready), 32'h1);
    checkOutput("w1_no_early_wen0", 32'(ram_write_en0), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 7'd0, 16'h0);
    checkOutput("w1_wen0", 32'(ram_write_en0), 32'h1);
    checkOutput("w1_addr0", 32'(ram_addr0), 32'h5);
    checkOutput("w1_din0", 32'(ram_din0), 32'h1234);
    checkOutput("w1_not_empty", 32'(wb_empty), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 7'd0, 16'h0);
    checkOutput("w1_empty_after", 32'(wb_empty), 32'h1);
    checkOutput("w1_wen0_after", 32'(ram_write_en0), 32'h0);
    checkOutput("ren0_static", 32'(ram_read_en0), 32'h0);
    checkOutput("wen1_static", 32'(ram_write_en1), 32'h0);
    checkOutput("din1_static", 32'(ram_din1), 32'h0);
    nextCycle();

    $display("[TB] four back-to-back writes");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 7'(8'h10 + k), 16'(16'h1000 + k));
      checkOutput("b2b_ready", 32'(req_ready), 32'h1);
      if (k > 0) begin
        checkOutput("b2b_wen0", 32'(ram_write_en0), 32'h1);
        checkOutput("b2b_addr0", 32'(ram_addr0), 32'(8'h10 + k - 1));
        checkOutput("b2b_din0", 32'(ram_din0), 32'(16'h1000 + k - 1));
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 7'd0, 16'h0);
    checkOutput("b2b_last_addr0", 32'(ram_addr0), 32'h13);
    checkOutput("b2b_last_din0", 32'(ram_din0), 32'h1003);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 7'd0, 16'h0);
    checkOutput("b2b_empty", 32'(wb_empty), 32'h1);
    nextCycle();

    $display("[TB] write then forwarded read");
    applyStimulus(1'b1, 1'b1, 7'd9, 16'hABCD);
    nextCycle();
    ram_dout1 = 16'h7777;
    applyStimulus(1'b1, 1'b0, 7'd9, 16'h0);
    checkOutput("fwd_ready", 32'(req_ready), 32'h1);
    checkOutput("fwd_ren1", 32'(ram_read_en1), 32'h0);
    checkOutput("fwd_drain", 32'(ram_write_en0), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 7'd0, 16'h0);
    checkOutput("fwd_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("fwd_rsp_rdata", 32'(rsp_rdata), 32'h004D);
    checkOutput("fwd_busy", 32'(req_ready), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 7'd0, 16'h0);
    checkOutput("fwd_rsp_done", 32'(rsp_valid), 32'h0);
    checkOutput("fwd_rsp_hold", 32'(rsp_rdata), 32'h004D);
    nextCycle();

    $display("[TB] read miss");
    ram_dout1 = 16'h0000;
    applyStimulus(1'b1, 1'b0, 7'd3, 16'h0);
    checkOutput("miss_ren1", 32'(ram_read_en1), 32'h1);
    checkOutput("miss_addr1", 32'(ram_addr1), 32'h3);
    nextCycle();
    ram_dout1 = 16'h0055;
    applyStimulus(1'b0, 1'b0, 7'd0, 16'h0);
    checkOutput("miss_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("miss_rsp_rdata", 32'(rsp_rdata), 32'h0055);
    checkOutput("miss_busy", 32'(req_ready), 32'h0);
    checkOutput("miss_ren1_wait", 32'(ram_read_en1), 32'h0);
    nextCycle();
    ram_dout1 = 16'hFFFF;
    applyStimulus(1'b0, 1'b0, 7'd0, 16'h0);
    checkOutput("miss_rsp_done", 32'(rsp_valid), 32'h0);
    checkOutput("miss_rsp_hold", 32'(rsp_rdata), 32'h0055);
    nextCycle();

    $display("[TB] newest entry wins");
    applyStimulus(1'b1, 1'b1, 7'd7, 16'h0011);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 7'd7, 16'h0022);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 7'd7, 16'h0);
    checkOutput("new_ren1", 32'(ram_read_en1), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 7'd0, 16'h0);
    checkOutput("new_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("new_rsp_rdata", 32'(rsp_rdata), 32'h0022);
    nextCycle();
    nextCycle();

    $display("[TB] reset mid-operation");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 7'(8'h20 + k), 16'(16'h2000 + k));
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 7'd0, 16'h0);
    checkOutput("pre_rst_wen0", 32'(ram_write_en0), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_wen0", 32'(ram_write_en0), 32'h0);
    checkOutput("mid_rst_empty", 32'(wb_empty), 32'h1);
    checkOutput("mid_rst_rdata", 32'(rsp_rdata), 32'h0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    nextCycle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput("post_rst_wen0", 32'(ram_write_en0), 32'h0);
      checkOutput("post_rst_empty", 32'(wb_empty), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
